// File: rtl/alu_pkg.sv
// Shared opcode map and MUL/DIV sequencer state encoding for alu_seq_param.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHRA = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_NEG  = 5'd12;
    localparam logic [4:0] OP_XOR  = 5'd13;
    localparam logic [4:0] OP_NOR  = 5'd14;
    localparam logic [4:0] OP_NOT  = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Shared iterative radix-2 engine: shift-add multiply / restoring divide on
// operand magnitudes, with sign correction applied combinationally on result.
module seq_muldiv_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           load,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           fin,
    output logic [2*W-1:0] result
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_mag;
    logic [CW-1:0]  r_cnt;
    logic           r_neg_a;
    logic           r_neg_b;
    logic           r_div;

    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W:0]     w_add;
    logic [W:0]     w_rsh;
    logic [W:0]     w_rem_try;
    logic [2*W-1:0] w_next;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;

    assign w_abs_a = a[W-1] ? ({W{1'b0}} - a) : a;
    assign w_abs_b = b[W-1] ? ({W{1'b0}} - b) : b;
    assign fin     = (r_cnt == CW'(1));

    // One iteration step: MUL adds into the high half then shifts right,
    // DIV shifts {rem,quo} left and keeps the trial subtraction if it fits.
    always_comb begin
        w_add     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag} : {(W+1){1'b0}});
        w_rsh     = r_acc[2*W-1:W-1];
        w_rem_try = w_rsh - {1'b0, r_mag};
        w_next    = r_acc;
        if (r_div) begin
            if (w_rsh >= {1'b0, r_mag}) begin
                w_next = {w_rem_try[W-1:0], r_acc[W-2:0], 1'b1};
            end else begin
                w_next = {w_rsh[W-1:0], r_acc[W-2:0], 1'b0};
            end
        end else begin
            w_next = {w_add, r_acc[W-1:1]};
        end
    end

    // Sign correction: product sign is sa^sb; quotient sign sa^sb, remainder follows A.
    always_comb begin
        w_quo  = r_acc[W-1:0];
        w_rem  = r_acc[2*W-1:W];
        result = r_acc;
        if (r_div) begin
            result = {(r_neg_a ? ({W{1'b0}} - w_rem) : w_rem),
                      ((r_neg_a ^ r_neg_b) ? ({W{1'b0}} - w_quo) : w_quo)};
        end else begin
            result = (r_neg_a ^ r_neg_b) ? ({(2*W){1'b0}} - r_acc) : r_acc;
        end
    end

    // Operand latch on load, then one step per edge until the counter drains.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_acc   <= {(2*W){1'b0}};
            r_mag   <= {W{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div   <= 1'b0;
        end else if (load) begin
            r_acc   <= is_div ? {{W{1'b0}}, w_abs_a} : {{W{1'b0}}, w_abs_b};
            r_mag   <= is_div ? w_abs_b : w_abs_a;
            r_cnt   <= CW'(W);
            r_neg_a <= a[W-1];
            r_neg_b <= b[W-1];
            r_div   <= is_div;
        end else if (r_cnt != {CW{1'b0}}) begin
            r_acc   <= w_next;
            r_cnt   <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked parametrised ALU: single-cycle ops registered in one edge,
// MUL/DIV sequenced through the shared iterative core.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [4:0]     opcode,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] C,
    output logic           div_by_zero
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2*W-1:0] r_c;
    logic           r_done;
    logic           r_busy;
    logic           r_dbz;

    logic [W-1:0]   w_single;
    logic [SHW-1:0] w_shamt;
    logic [2*W-1:0] w_dbl;
    logic [2*W-1:0] w_ror_full;
    logic [2*W-1:0] w_rol_full;
    logic           w_b_zero;
    logic           w_is_div;
    logic           w_iter;
    logic           w_load;
    logic           w_fin;
    logic [2*W-1:0] w_core_res;

    assign busy        = r_busy;
    assign done        = r_done;
    assign C           = r_c;
    assign div_by_zero = r_dbz;

    assign w_shamt  = B[SHW-1:0];
    assign w_b_zero = (B == {W{1'b0}});
    assign w_is_div = (opcode == OP_DIV);
    assign w_iter   = (opcode == OP_MUL) || (w_is_div && !w_b_zero);

    seq_muldiv_core #(.W(W)) u_core (
        .clk    (clk),
        .clr    (clr),
        .load   (w_load),
        .is_div (w_is_div),
        .a      (A),
        .b      (B),
        .fin    (w_fin),
        .result (w_core_res)
    );

    // Single-cycle datapath; rotates use a doubled copy of A so amount 0 is safe.
    always_comb begin
        w_dbl      = {A, A};
        w_ror_full = w_dbl >> w_shamt;
        w_rol_full = w_dbl << w_shamt;
        w_single   = {W{1'b0}};
        case (opcode)
            OP_ADD:  w_single = A + B;
            OP_SUB:  w_single = A - B;
            OP_SHR:  w_single = A >> w_shamt;
            OP_SHL:  w_single = A << w_shamt;
            OP_SHRA: w_single = $signed(A) >>> w_shamt;
            OP_ROR:  w_single = w_ror_full[W-1:0];
            OP_ROL:  w_single = w_rol_full[2*W-1:W];
            OP_AND:  w_single = A & B;
            OP_OR:   w_single = A | B;
            OP_NEG:  w_single = {W{1'b0}} - B;
            OP_XOR:  w_single = A ^ B;
            OP_NOR:  w_single = ~(A | B);
            OP_NOT:  w_single = ~B;
            default: w_single = {W{1'b0}};
        endcase
    end

    // Sequencer next state and core load strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_iter) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_fin) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output registers and handshake; clr dominates any concurrent start.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_c     <= {(2*W){1'b0}};
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dbz <= 1'b0;
                        if (w_iter) begin
                            r_busy <= 1'b1;
                        end else if (w_is_div) begin
                            r_c    <= {A, {W{1'b1}}};
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_c    <= {{W{1'b0}}, w_single};
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b1;
                end
                ST_FIX: begin
                    r_c    <= w_core_res;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed self-checking bench for alu_seq_param (W=32 and W=8 instances).
module tb_alu_seq_param;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] A, B;
    logic        busy, done, dbz;
    logic [63:0] C;

    logic        s8_start;
    logic [4:0]  s8_opcode;
    logic [7:0]  s8_A, s8_B;
    logic        s8_busy, s8_done, s8_dbz;
    logic [15:0] s8_C;

    int errors = 0;
    int checks = 0;
    int lat, bcnt, npulse;

    always #5 clk = ~clk;

    alu_seq_param #(.W(32)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .A(A), .B(B),
        .busy(busy), .done(done), .C(C), .div_by_zero(dbz)
    );

    alu_seq_param #(.W(8)) dut8 (
        .clk(clk), .clr(clr), .start(s8_start), .opcode(s8_opcode), .A(s8_A), .B(s8_B),
        .busy(s8_busy), .done(s8_done), .C(s8_C), .div_by_zero(s8_dbz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; optionally poke start (as ADD) while busy at edge poke_at.
    task automatic op32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output int l, output int bc);
        @(negedge clk);
        opcode = op; A = a; B = b; start = 1'b1;
        l = 0; bc = 0;
        while (l < 100) begin
            @(posedge clk); #1;
            l++;
            if (busy) bc++;
            if (done) break;
            if (l == poke_at) begin
                start = 1'b1; opcode = OP_ADD;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic pulse_chk(input string tag);
        @(posedge clk); #1;
        chk(tag, {63'd0, done}, 64'd0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; opcode = 5'd0; A = 32'd0; B = 32'd0;
        s8_start = 1'b0; s8_opcode = 5'd0; s8_A = 8'd0; s8_B = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_C", C, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dbz", {63'd0, dbz}, 64'd0);
        clr = 1'b0;

        op32(OP_ADD, 32'hFFFF_FFFF, 32'd2, 0, lat, bcnt);
        chk("add_done", {63'd0, done}, 64'd1);
        chk("add_C", C, 64'h0000_0000_0000_0001);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_busy", 64'(bcnt), 64'd0);
        pulse_chk("add_pulse");

        op32(OP_MUL, 32'hFFFF_FFFD, 32'd7, 5, lat, bcnt);
        chk("mul_done", {63'd0, done}, 64'd1);
        chk("mul_C", C, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_lat", 64'(lat), 64'd34);
        chk("mul_busy", 64'(bcnt), 64'd33);
        pulse_chk("mul_pulse");

        op32(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, lat, bcnt);
        chk("div_C", C, 64'h0000_0002_FFFF_FFF2);
        chk("div_dbz", {63'd0, dbz}, 64'd0);
        chk("div_lat", 64'(lat), 64'd34);

        op32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
        chk("divwrap_C", C, 64'h0000_0000_8000_0000);

        op32(OP_DIV, 32'h1234_5678, 32'd0, 0, lat, bcnt);
        chk("dz_done", {63'd0, done}, 64'd1);
        chk("dz_dbz", {63'd0, dbz}, 64'd1);
        chk("dz_C", C, 64'h1234_5678_FFFF_FFFF);
        chk("dz_lat", 64'(lat), 64'd1);

        op32(OP_SHRA, 32'h8000_0010, 32'h0000_0024, 0, lat, bcnt);
        chk("shra_C", C, 64'h0000_0000_F800_0001);
        chk("shra_dbz_clr", {63'd0, dbz}, 64'd0);

        op32(OP_ROL, 32'h8000_0001, 32'h0000_0024, 0, lat, bcnt);
        chk("rol_C", C, 64'h0000_0000_0000_0018);
        op32(OP_ROR, 32'h0000_0011, 32'h0000_0004, 0, lat, bcnt);
        chk("ror_C", C, 64'h0000_0000_1000_0001);
        op32(OP_SUB, 32'd5, 32'd7, 0, lat, bcnt);
        chk("sub_C", C, 64'h0000_0000_FFFF_FFFE);
        op32(OP_NEG, 32'd9, 32'd1, 0, lat, bcnt);
        chk("neg_C", C, 64'h0000_0000_FFFF_FFFF);
        op32(OP_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 0, lat, bcnt);
        chk("nor_C", C, 64'h0000_0000_0F0F_F0F0);

        // Abort a running MUL with clr after 10 edges.
        @(negedge clk);
        opcode = OP_MUL; A = 32'd5; B = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_pre", {63'd0, busy}, 64'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("abort_C", C, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        npulse = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        chk("abort_no_done", 64'(npulse), 64'd0);
        op32(OP_ADD, 32'd3, 32'd4, 0, lat, bcnt);
        chk("post_abort_C", C, 64'd7);
        chk("post_abort_lat", 64'(lat), 64'd1);

        op32(5'h1F, 32'h1234_0000, 32'h0000_5678, 0, lat, bcnt);
        chk("unk_done", {63'd0, done}, 64'd1);
        chk("unk_C", C, 64'd0);

        // W=8 instance: MUL 0x80 * 0x80.
        @(negedge clk);
        s8_opcode = OP_MUL; s8_A = 8'h80; s8_B = 8'h80; s8_start = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            s8_start = 1'b0;
            if (s8_done) break;
        end
        chk("w8_done", {63'd0, s8_done}, 64'd1);
        chk("w8_C", {48'd0, s8_C}, 64'h0000_0000_0000_4000);
        chk("w8_lat", 64'(lat), 64'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
